seg_scan_driver: RTL

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_pkg.sv | 40 ++++
 rtl/seg_glyph_rom.sv | 11 +
 rtl/seg_scan_driver.sv | 138 +++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Glyph codes, segment patterns and polarity-neutral constants shared by the
// seven-segment scan driver and its decode ROM.
package seg_pkg;

   localparam int SEG_W = 7;

   localparam logic [3:0] GLYPH_L     = 4'd10;
   localparam logic [3:0] GLYPH_R     = 4'd11;
   localparam logic [3:0] GLYPH_DASH  = 4'd12;
   localparam logic [3:0] GLYPH_H     = 4'd13;
   localparam logic [3:0] GLYPH_P     = 4'd14;
   localparam logic [3:0] GLYPH_BLANK = 4'd15;

   localparam logic [SEG_W-1:0] SEG_OFF = 7'b0000000;

   // Segment order {g,f,e,d,c,b,a}; packed concatenation lists entry 15 first.
   localparam logic [15:0][SEG_W-1:0] GLYPH_TAB = {
      7'b0000000,
      7'b1110011,
      7'b1110110,
      7'b1000000,
      7'b1010000,
      7'b0111000,
      7'b1101111,
      7'b1111111,
      7'b0000111,
      7'b1111101,
      7'b1101101,
      7'b1100110,
      7'b1001111,
      7'b1011011,
      7'b0000110,
      7'b0111111
   };

   function automatic logic [SEG_W-1:0] glyph_seg(input logic [3:0] code);
      return GLYPH_TAB[code];
   endfunction

endpackage

// File: rtl/seg_glyph_rom.sv
// Combinational 4-bit glyph code to active-high segment pattern decode.
module seg_glyph_rom
   import seg_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg
);

   assign seg = glyph_seg(code);

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver with prescaled slots and a one-cycle
// anti-ghost gap after every slot boundary. Define SEG_SCAN_BLINK_EN to add blink.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int CLK_DIV     = 50000,
   parameter int BLINK_SLOTS = 256,
   parameter int ACTIVE_LOW  = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [4*DIGITS-1:0] codes,
   input  logic [DIGITS-1:0]   blank,
   input  logic [DIGITS-1:0]   blink,
   output logic [6:0]          seg,
   output logic [DIGITS-1:0]   an,
   output logic                tick
);

   localparam int   CW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int   IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic POL = (ACTIVE_LOW != 0);

   if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
      $error("seg_scan_driver: DIGITS must be 1..8");
   end
   if (CLK_DIV < 2) begin : g_bad_div
      $error("seg_scan_driver: CLK_DIV must be >= 2");
   end
   if (BLINK_SLOTS < 1) begin : g_bad_blink
      $error("seg_scan_driver: BLINK_SLOTS must be >= 1");
   end

   logic [CW-1:0]            cnt;
   logic [IW-1:0]            idx;
   logic [DIGITS-1:0][3:0]   codes_sh;
   logic [DIGITS-1:0]        blank_sh;
   logic [DIGITS-1:0]        dark;
   logic [DIGITS-1:0][6:0]   glyph;
   logic [6:0]               seg_nx;
   logic [DIGITS-1:0]        an_nx;

   // Slot prescaler; tick is decoded from the count so it lines up with the wrap.
   assign tick = (cnt == CW'(CLK_DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       cnt <= '0;
      else if (tick) cnt <= '0;
      else           cnt <= cnt + CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         idx <= '0;
      else if (tick)
         idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         codes_sh <= {DIGITS{GLYPH_BLANK}};
         blank_sh <= '1;
      end else if (load) begin
         codes_sh <= codes;
         blank_sh <= blank;
      end
   end

`ifdef SEG_SCAN_BLINK_EN
   localparam int BW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;

   logic [BW-1:0]     bcnt;
   logic              phase;
   logic [DIGITS-1:0] blink_sh;

   // Phase flips every BLINK_SLOTS slot boundaries; blinking digits go dark while it is 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcnt     <= '0;
         phase    <= 1'b0;
         blink_sh <= '0;
      end else begin
         if (load)
            blink_sh <= blink;
         if (tick) begin
            if (bcnt == BW'(BLINK_SLOTS - 1)) begin
               bcnt  <= '0;
               phase <= ~phase;
            end else begin
               bcnt <= bcnt + BW'(1);
            end
         end
      end
   end

   assign dark = blank_sh | (blink_sh & {DIGITS{phase}});
`else
   logic unused_blink;
   assign unused_blink = ^blink;
   assign dark         = blank_sh;
`endif

   for (genvar i = 0; i < DIGITS; i++) begin : g_rom
      seg_glyph_rom u_rom (
         .code (codes_sh[i]),
         .seg  (glyph[i])
      );
   end

   // During the tick cycle the next register value is the all-off gap, so the
   // new slot never shows the previous digit's glyph on the new anode.
   always_comb begin
      seg_nx = SEG_OFF;
      an_nx  = '0;
      if (!tick) begin
         for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
               an_nx[i] = 1'b1;
               if (!dark[i])
                  seg_nx = glyph[i];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg <= SEG_OFF ^ {7{POL}};
         an  <= {DIGITS{POL}};
      end else begin
         seg <= seg_nx ^ {7{POL}};
         an  <= an_nx ^ {DIGITS{POL}};
      end
   end

endmodule
